// File: rtl/factorial_ctrl.sv
// ---------------------------------------------------------------------------
// factorial_ctrl
//   Control FSM for the 8-bit factorial datapath. On start it latches n_i and
//   sequences the datapath: it loads the register file (R0 = counter,
//   R1 = product, R2 = constant 1), runs the multiply/decrement loop until the
//   datapath compare flag reports ALU == 1, then loads the output register
//   and pulses done. An operand above N_MAX cannot be represented in 8 bits,
//   so it is answered with done+err immediately and Out is left untouched.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous reset, active-high
//   start    in   1  begin computation (sampled only in IDLE)
//   n_i      in   8  operand, sampled with start
//   compare  in   1  datapath flag, combinational (ALU out == 1)
//   data_o   out  8  immediate data to datapath Data_i
//   IE       out  1  datapath input mux: 1 = data_o, 0 = ALU
//   we       out  1  RF write enable
//   wa       out  2  RF write address
//   rea/reb  out  1  RF read enables A/B
//   raa/rab  out  2  RF read addresses A/B
//   Sel_alu  out  3  ALU operation
//   OE       out  1  output-register load enable
//   busy     out  1  high in every state except IDLE
//   done     out  1  one-cycle pulse, result valid on datapath Out
//   err      out  1  qualifies done: operand too large, Out not updated
// ---------------------------------------------------------------------------
module factorial_ctrl #(
   parameter logic [7:0] N_MAX = 8'd5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] n_i,
   input  logic       compare,
   output logic [7:0] data_o,
   output logic       IE,
   output logic       we,
   output logic [1:0] wa,
   output logic       rea,
   output logic       reb,
   output logic [1:0] raa,
   output logic [1:0] rab,
   output logic [2:0] Sel_alu,
   output logic       OE,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // ALU operation codes understood by the datapath.
   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_PASS = 3'b011
   } alu_op_e;

   // Register-file map.
   localparam logic [1:0] R_CNT  = 2'd0;
   localparam logic [1:0] R_PROD = 2'd1;
   localparam logic [1:0] R_ONE  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_N,
      S_LOAD_P,
      S_LOAD_K,
      S_CHECK,
      S_MUL,
      S_DEC,
      S_OUT,
      S_DONE
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] n_q, n_d;
   logic       err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         err_q   <= err_d;
      end
   end

   // Next state plus Moore output decode. Outputs depend on state_q only,
   // so compare never feeds back combinationally into the datapath controls.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      err_d   = err_q;
      data_o  = 8'd0;
      IE      = 1'b0;
      we      = 1'b0;
      wa      = 2'd0;
      rea     = 1'b0;
      reb     = 1'b0;
      raa     = 2'd0;
      rab     = 2'd0;
      Sel_alu = OP_ADD;
      OE      = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (n_i > N_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  n_d     = n_i;
                  err_d   = 1'b0;
                  state_d = S_LOAD_N;
               end
            end
         end
         S_LOAD_N: begin
            IE      = 1'b1;
            data_o  = n_q;
            we      = 1'b1;
            wa      = R_CNT;
            state_d = S_LOAD_P;
         end
         S_LOAD_P: begin
            IE      = 1'b1;
            data_o  = 8'd1;
            we      = 1'b1;
            wa      = R_PROD;
            state_d = S_LOAD_K;
         end
         S_LOAD_K: begin
            IE      = 1'b1;
            data_o  = 8'd1;
            we      = 1'b1;
            wa      = R_ONE;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            // Counter passed through the ALU: 1 means product already final.
            // n == 0 would never reach 1 by decrementing, so it exits here too.
            rea     = 1'b1;
            raa     = R_CNT;
            Sel_alu = OP_PASS;
            state_d = (compare || n_q == 8'd0) ? S_OUT : S_MUL;
         end
         S_MUL: begin
            rea     = 1'b1;
            reb     = 1'b1;
            raa     = R_PROD;
            rab     = R_CNT;
            Sel_alu = OP_MUL;
            we      = 1'b1;
            wa      = R_PROD;
            state_d = S_DEC;
         end
         S_DEC: begin
            // compare looks at the value being written back: new counter == 1.
            rea     = 1'b1;
            reb     = 1'b1;
            raa     = R_CNT;
            rab     = R_ONE;
            Sel_alu = OP_SUB;
            we      = 1'b1;
            wa      = R_CNT;
            state_d = compare ? S_OUT : S_MUL;
         end
         S_OUT: begin
            rea     = 1'b1;
            raa     = R_PROD;
            Sel_alu = OP_PASS;
            OE      = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_factorial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_factorial_ctrl
//   Bench for factorial_ctrl with a behavioural model of the datapath
//   (4x8 register file, ALU, input mux, output register). Stimulus pushes the
//   hand-computed expectation for each start into a queue; an independent
//   monitor pops and checks Out, err, latency and OE count on every done.
// ---------------------------------------------------------------------------
module tb_factorial_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] n_i = 8'd0;
   logic       compare;
   logic [7:0] data_o;
   logic       IE, we, rea, reb, OE, busy, done, err;
   logic [1:0] wa, raa, rab;
   logic [2:0] Sel_alu;

   factorial_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .n_i     (n_i),
      .compare (compare),
      .data_o  (data_o),
      .IE      (IE),
      .we      (we),
      .wa      (wa),
      .rea     (rea),
      .reb     (reb),
      .raa     (raa),
      .rab     (rab),
      .Sel_alu (Sel_alu),
      .OE      (OE),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   // ---------------- datapath model ----------------
   logic [7:0] rf [4];
   logic [7:0] out_reg = 8'd0;
   logic [7:0] a_val, b_val, alu_val, wdata;
   logic [15:0] prod;

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = 8'd0;
   end

   always_comb begin
      a_val = rea ? rf[raa] : 8'd0;
      b_val = reb ? rf[rab] : 8'd0;
      prod  = 16'(a_val) * 16'(b_val);
      case (Sel_alu)
         3'b000:  alu_val = a_val + b_val;
         3'b001:  alu_val = a_val - b_val;
         3'b010:  alu_val = prod[7:0];
         3'b011:  alu_val = a_val;
         default: alu_val = 8'd0;
      endcase
      wdata   = IE ? data_o : alu_val;
      compare = (alu_val == 8'd1);
   end

   always @(posedge clk) begin
      if (we) rf[wa] <= wdata;
      if (OE) out_reg <= alu_val;
   end

   // ---------------- bookkeeping ----------------
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int oe_cnt = 0;
   int oe_total = 0;
   int done_total = 0;

   typedef struct {
      int          n;
      int          out;
      int          err;
      int          lat;
      int          oe;
      int unsigned t0;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         oe_cnt = 0;
      end else begin
         if (OE) begin
            oe_cnt++;
            oe_total++;
         end
         if (done) begin
            done_total++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check($sformatf("out_n%0d", e.n), int'(out_reg), e.out);
               check($sformatf("err_n%0d", e.n), int'(err), e.err);
               check($sformatf("latency_n%0d", e.n), int'(cyc - e.t0), e.lat);
               check($sformatf("oe_count_n%0d", e.n), oe_cnt, e.oe);
               $display("txn n=%0d out=%0d err=%0b latency=%0d oe=%0d",
                        e.n, out_reg, err, cyc - e.t0, oe_cnt);
            end
            oe_cnt = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [24:0] all_outs();
      return {data_o, IE, we, wa, rea, reb, raa, rab, Sel_alu, OE, busy, done, err};
   endfunction

   task automatic issue(input int n, input int out, input int e_err,
                        input int lat, input int oe, output int unsigned t0);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      n_i   = 8'(n);
      t0    = cyc;
      e.n = n; e.out = out; e.err = e_err; e.lat = lat; e.oe = oe; e.t0 = t0;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int budget = 40;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input int out, input int e_err,
                      input int lat, input int oe);
      int unsigned t0;
      issue(n, out, e_err, lat, oe, t0);
      wait_drain();
   endtask

   task automatic wait_cycle(input int unsigned target);
      int budget = 40;
      while (cyc != target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("cycle_reach", int'(cyc), int'(target));
   endtask

   initial begin
      int unsigned t0;
      int oe_snap, done_snap;

      // Reset held 3 cycles with start asserted: must be ignored.
      rst = 1'b1; start = 1'b1; n_i = 8'd3;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'(all_outs()), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset_busy", int'(busy), 0);

      //   n  Out err lat OE
      run(3,   6, 0, 10, 1);
      run(5, 120, 0, 14, 1);
      run(6, 120, 1,  1, 0);   // too large: Out keeps previous 120
      run(1,   1, 0,  6, 1);
      run(0,   1, 0,  6, 1);
      run(2,   2, 0,  8, 1);
      run(255, 2, 1,  1, 0);

      // Start (n_i=2) pulsed while the n=3 run is in its first MUL: ignored.
      issue(3, 6, 0, 10, 1, t0);
      wait_cycle(t0 + 5);
      check("busy_in_mul", int'(busy), 1);
      start = 1'b1; n_i = 8'd2;
      @(negedge clk);
      start = 1'b0;
      wait_drain();

      // Abort an n=4 run in its first DEC: no OE, no done afterwards.
      @(negedge clk);
      start = 1'b1; n_i = 8'd4; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      wait_cycle(t0 + 6);
      oe_snap = oe_total; done_snap = done_total;
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs", int'(all_outs()), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_oe", oe_total - oe_snap, 0);
      check("abort_no_done", done_total - done_snap, 0);
      $display("txn abort n=4 oe=%0d done=%0d", oe_total - oe_snap, done_total - done_snap);

      run(4, 24, 0, 12, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
